// File: rtl/bananachine_ctrl_if.sv
// Control bus between the Bananachine control unit and its datapath.
// Carries the decoded instruction fields and flags into the controller and
// every datapath select/enable plus the memory write strobe back out.
//   master : control unit (reads fields/flags, drives controls)
//   slave  : datapath     (drives fields/flags, reads controls)
interface bananachine_ctrl_if #(
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4,
    parameter int REG_BITS         = 4,
    parameter int ALU_CONT_BITS    = 6,
    parameter int WIDTH            = 16
);
    logic [OP_CODE_BITS-1:0]     op_code;
    logic [EXT_OP_CODE_BITS-1:0] ext_op_code;
    logic [REG_BITS-1:0]         A_index;
    logic [WIDTH-1:0]            psr_flags;
    logic                        reg_write;
    logic                        alu_A_src;
    logic                        alu_B_src;
    logic                        pc_en;
    logic [1:0]                  pc_src;
    logic [1:0]                  reg_write_src;
    logic                        loading;
    logic                        storing;
    logic                        mem_write;
    logic                        instruction_en;
    logic [ALU_CONT_BITS-1:0]    alu_cont;
    logic                        retire;
    logic                        illegal;

    modport master (
        input  op_code, ext_op_code, A_index, psr_flags,
        output reg_write, alu_A_src, alu_B_src, pc_en, pc_src, reg_write_src,
               loading, storing, mem_write, instruction_en, alu_cont,
               retire, illegal
    );

    modport slave (
        output op_code, ext_op_code, A_index, psr_flags,
        input  reg_write, alu_A_src, alu_B_src, pc_en, pc_src, reg_write_src,
               loading, storing, mem_write, instruction_en, alu_cont,
               retire, illegal
    );
endinterface

// File: rtl/bananachine_ctrl.sv
// Bananachine multicycle control unit (Moore FSM).
// Sequences FETCH -> LATCH -> DECODE -> execute/memory/writeback and drives
// all datapath selects and enables from the instruction fields and flags.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset (FSM returns to FETCH)
//   mem_ready  : memory ready (only with BANANA_MEM_WAIT_EN defined)
//   bus        : bananachine_ctrl_if.master (fields/flags in, controls out)
// Optional feature macro: BANANA_MEM_WAIT_EN -- FETCH, LOAD_A and STORE wait
// for mem_ready; when undefined memory is always ready.
module bananachine_ctrl #(
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4,
    parameter int REG_BITS         = 4,
    parameter int ALU_CONT_BITS    = 6,
    parameter int WIDTH            = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef BANANA_MEM_WAIT_EN
    input  logic mem_ready,
`endif
    bananachine_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH, LATCH, DECODE, EXEC_R, EXEC_I, LOAD_A, LOAD_WB,
        STORE, JAL, JCOND, BRANCH, ILLEGAL
    } state_t;

    state_t state, next;

    logic [OP_CODE_BITS-1:0]     op;
    logic [EXT_OP_CODE_BITS-1:0] ext;
    logic [REG_BITS-1:0]         cc;
    logic [WIDTH-1:0]            flags;
    logic                        mem_rdy;
    logic                        cond;

    assign op    = bus.op_code;
    assign ext   = bus.ext_op_code;
    assign cc    = bus.A_index;
    assign flags = bus.psr_flags;

`ifdef BANANA_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Flag bits the condition decoder ignores.
    logic unused_flags;
    assign unused_flags = ^{flags[WIDTH-1:8], flags[4:3], flags[1]};

    // Condition decode; reserved codes are never taken.
    always_comb begin
        case (cc)
            4'b0000: cond =  flags[6];
            4'b0001: cond = !flags[6];
            4'b0010: cond =  flags[0];
            4'b0011: cond = !flags[0];
            4'b0100: cond =  flags[2];
            4'b0101: cond = !flags[2];
            4'b0110: cond =  flags[7];
            4'b0111: cond = !flags[7];
            4'b1000: cond =  flags[5];
            4'b1001: cond = !flags[5];
            4'b1110: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    logic                     reg_write, alu_A_src, alu_B_src, pc_en;
    logic [1:0]               pc_src, reg_write_src;
    logic                     loading, storing, mem_write, instruction_en;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic                     retire, illegal;

    always_comb begin
        next           = state;
        reg_write      = 1'b0;
        alu_A_src      = 1'b0;
        alu_B_src      = 1'b0;
        pc_en          = 1'b0;
        pc_src         = 2'd2;
        reg_write_src  = 2'd0;
        loading        = 1'b0;
        storing        = 1'b0;
        mem_write      = 1'b0;
        instruction_en = 1'b0;
        alu_cont       = '0;
        retire         = 1'b0;
        illegal        = 1'b0;
        case (state)
            FETCH: if (mem_rdy) next = LATCH;
            LATCH: begin
                instruction_en = 1'b1;
                next           = DECODE;
            end
            DECODE: begin
                case (op)
                    4'b0000: next = EXEC_R;
                    4'b0100: begin
                        case (ext)
                            4'b0000: next = LOAD_A;
                            4'b0100: next = STORE;
                            4'b1000: next = JAL;
                            4'b1100: next = JCOND;
                            default: next = ILLEGAL;
                        endcase
                    end
                    4'b1100: next = BRANCH;
                    4'b0001, 4'b0010, 4'b0011, 4'b0101,
                    4'b1001, 4'b1011, 4'b1101, 4'b1111: next = EXEC_I;
                    default: next = ILLEGAL;
                endcase
            end
            EXEC_R, EXEC_I: begin
                alu_A_src = 1'b1;
                alu_B_src = (state == EXEC_I);
                // CMP / CMPI only update flags, never the register file.
                if (state == EXEC_R) begin
                    alu_cont  = ALU_CONT_BITS'({2'b00, ext});
                    reg_write = (ext != 4'b1011);
                end else begin
                    alu_cont  = ALU_CONT_BITS'({2'b01, op});
                    reg_write = (op != 4'b1011);
                end
                pc_en  = 1'b1;
                retire = 1'b1;
                next   = FETCH;
            end
            LOAD_A: begin
                loading = 1'b1;
                if (mem_rdy) next = LOAD_WB;
            end
            LOAD_WB: begin
                loading       = 1'b1;
                reg_write     = 1'b1;
                reg_write_src = 2'd1;
                pc_en         = 1'b1;
                retire        = 1'b1;
                next          = FETCH;
            end
            STORE: begin
                // Strobe stays up while waiting; commit only once memory accepts.
                storing   = 1'b1;
                mem_write = 1'b1;
                pc_en     = mem_rdy;
                retire    = mem_rdy;
                if (mem_rdy) next = FETCH;
            end
            JAL: begin
                reg_write     = 1'b1;
                reg_write_src = 2'd2;
                pc_src        = 2'd1;
                pc_en         = 1'b1;
                retire        = 1'b1;
                next          = FETCH;
            end
            JCOND: begin
                pc_src = cond ? 2'd1 : 2'd2;
                pc_en  = 1'b1;
                retire = 1'b1;
                next   = FETCH;
            end
            BRANCH: begin
                alu_B_src = 1'b1;
                alu_cont  = ALU_CONT_BITS'(6'b000101);
                pc_src    = cond ? 2'd0 : 2'd2;
                pc_en     = 1'b1;
                retire    = 1'b1;
                next      = FETCH;
            end
            ILLEGAL: begin
                pc_en   = 1'b1;
                illegal = 1'b1;
                retire  = 1'b1;
                next    = FETCH;
            end
            default: next = FETCH;
        endcase
    end

    assign bus.reg_write      = reg_write;
    assign bus.alu_A_src      = alu_A_src;
    assign bus.alu_B_src      = alu_B_src;
    assign bus.pc_en          = pc_en;
    assign bus.pc_src         = pc_src;
    assign bus.reg_write_src  = reg_write_src;
    assign bus.loading        = loading;
    assign bus.storing        = storing;
    assign bus.mem_write      = mem_write;
    assign bus.instruction_en = instruction_en;
    assign bus.alu_cont       = alu_cont;
    assign bus.retire         = retire;
    assign bus.illegal        = illegal;

endmodule
